// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle RV32I-subset control unit.
// Holds the ALU operation codes, opcode/funct3 constants, state encodings
// and datapath mux-select encodings used by the controller and its decoder.
// No ports.
package multicycle_control_pkg;

    // ALU operation codes shared with the datapath ALU.
    localparam int unsigned ALU_W = 5;

    localparam logic [ALU_W-1:0] ALU_ADD = 5'd0;
    localparam logic [ALU_W-1:0] ALU_SUB = 5'd1;
    localparam logic [ALU_W-1:0] ALU_AND = 5'd2;
    localparam logic [ALU_W-1:0] ALU_OR  = 5'd3;
    localparam logic [ALU_W-1:0] ALU_SLT = 5'd4;

    // Major opcodes (IR[6:0]).
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // funct3 values (IR[14:12]).
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // ALU A input select.
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_REGA  = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    // ALU B input select.
    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    // Register writeback select.
    localparam logic [1:0] MTR_ALUOUT = 2'b00;
    localparam logic [1:0] MTR_MDR    = 2'b01;
    localparam logic [1:0] MTR_PC     = 2'b10;

    // Controller states; encodings 11..15 are unused and recover to StFetch.
    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StExecR    = 4'd2,
        StExecI    = 4'd3,
        StAluWb    = 4'd4,
        StMemAddr  = 4'd5,
        StMemRead  = 4'd6,
        StMemWb    = 4'd7,
        StMemWrite = 4'd8,
        StBranch   = 4'd9,
        StJal      = 4'd10
    } state_e;

    // What the ALU op decoder should produce this cycle.
    typedef enum logic [1:0] {
        ClsR   = 2'd0,
        ClsI   = 2'd1,
        ClsAdd = 2'd2,
        ClsSub = 2'd3
    } alu_class_e;

endpackage

// File: rtl/multicycle_control_alu_op_decoder.sv
// Combinational ALU operation decoder.
// Ports:
//   alu_class_i  operation class: R-type, I-type, forced ADD, forced SUB
//   funct3_i     IR[14:12]
//   funct7b5_i   IR[30], selects SUB for R-type funct3 000
//   alu_op_o     shared ALU_* operation code
//   legal_o      low when the funct combination is unsupported for the class
module multicycle_control_alu_op_decoder
    import multicycle_control_pkg::*;
(
    input  alu_class_e       alu_class_i,
    input  logic [2:0]       funct3_i,
    input  logic             funct7b5_i,
    output logic [ALU_W-1:0] alu_op_o,
    output logic             legal_o
);

    always_comb begin
        alu_op_o = ALU_ADD;
        legal_o  = 1'b1;
        case (alu_class_i)
            ClsR: begin
                case (funct3_i)
                    F3_ADD:  alu_op_o = funct7b5_i ? ALU_SUB : ALU_ADD;
                    F3_AND:  alu_op_o = ALU_AND;
                    F3_OR:   alu_op_o = ALU_OR;
                    F3_SLT:  alu_op_o = ALU_SLT;
                    default: legal_o  = 1'b0;
                endcase
            end
            ClsI: begin
                // funct7b5 is part of the immediate here, so it is ignored.
                case (funct3_i)
                    F3_ADD:  alu_op_o = ALU_ADD;
                    F3_AND:  alu_op_o = ALU_AND;
                    F3_OR:   alu_op_o = ALU_OR;
                    F3_SLT:  alu_op_o = ALU_SLT;
                    default: legal_o  = 1'b0;
                endcase
            end
            ClsSub:  alu_op_o = ALU_SUB;
            default: alu_op_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I-subset control unit (fetch/decode/execute/memory/writeback).
// Drives the ALU operation code and datapath mux selects and handshakes with a
// variable-latency memory through iMemReady.
// Ports:
//   iCLK, iRST              clock (rising edge), async active-high reset
//   iOpcode/iFunct3/iFunct7b5  instruction fields from IR
//   iZero                   ALU result is zero (branch condition)
//   iMemReady               memory transfer completes this cycle
//   oPCWrite, oIRWrite      PC / IR+oldPC load enables
//   oMemRead, oMemWrite     memory requests, oIorD address select
//   oRegWrite, oMemToReg    register writeback enable and source
//   oALUSrcA/B, oPCSource   datapath mux selects
//   oALUControl             ALU operation code
//   oIllegal                one-cycle pulse on an unsupported instruction
//   oState                  current state (debug)
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned ALUW = 5,
    parameter int unsigned STW  = 4
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic [6:0]      iOpcode,
    input  logic [2:0]      iFunct3,
    input  logic            iFunct7b5,
    input  logic            iZero,
    input  logic            iMemReady,
    output logic            oPCWrite,
    output logic            oIRWrite,
    output logic            oMemRead,
    output logic            oMemWrite,
    output logic            oIorD,
    output logic            oRegWrite,
    output logic [1:0]      oMemToReg,
    output logic [1:0]      oALUSrcA,
    output logic [1:0]      oALUSrcB,
    output logic            oPCSource,
    output logic [ALUW-1:0] oALUControl,
    output logic            oIllegal,
    output logic [STW-1:0]  oState
);

    state_e           state_q, state_d;
    alu_class_e       alu_class;
    logic [ALU_W-1:0] alu_op;
    logic             alu_legal;

    logic       pc_write, ir_write, mem_read, mem_write, iord, reg_write, illegal, pc_source;
    logic [1:0] mem_to_reg, alu_src_a, alu_src_b;

    multicycle_control_alu_op_decoder u_alu_op_decoder (
        .alu_class_i (alu_class),
        .funct3_i    (iFunct3),
        .funct7b5_i  (iFunct7b5),
        .alu_op_o    (alu_op),
        .legal_o     (alu_legal)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and Moore outputs; only FETCH (iMemReady) and BRANCH (iZero)
    // gate enables with inputs, plus the illegal-instruction pulse.
    always_comb begin
        state_d    = StFetch;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        pc_source  = 1'b0;
        mem_to_reg = MTR_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_REGB;
        alu_class  = ClsAdd;
        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (iMemReady) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end else begin
                    state_d  = StFetch;
                end
            end
            StDecode: begin
                // Branch/jump target is computed here and latched into ALUOut.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (iOpcode)
                    OP_RTYPE:          state_d = StExecR;
                    OP_ITYPE:          state_d = StExecI;
                    OP_LOAD, OP_STORE: state_d = StMemAddr;
                    OP_BRANCH:         state_d = StBranch;
                    OP_JAL:            state_d = StJal;
                    default:           illegal = 1'b1;
                endcase
            end
            StExecR: begin
                alu_src_a = SRCA_REGA;
                alu_src_b = SRCB_REGB;
                alu_class = ClsR;
                if (alu_legal) begin
                    state_d = StAluWb;
                end else begin
                    illegal = 1'b1;
                end
            end
            StExecI: begin
                alu_src_a = SRCA_REGA;
                alu_src_b = SRCB_IMM;
                alu_class = ClsI;
                if (alu_legal) begin
                    state_d = StAluWb;
                end else begin
                    illegal = 1'b1;
                end
            end
            StAluWb: begin
                reg_write  = 1'b1;
                mem_to_reg = MTR_ALUOUT;
            end
            StMemAddr: begin
                alu_src_a = SRCA_REGA;
                alu_src_b = SRCB_IMM;
                if (iOpcode == OP_LOAD) begin
                    state_d = StMemRead;
                end else if (iOpcode == OP_STORE) begin
                    state_d = StMemWrite;
                end
            end
            StMemRead: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = iMemReady ? StMemWb : StMemRead;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = MTR_MDR;
            end
            StMemWrite: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                state_d   = iMemReady ? StFetch : StMemWrite;
            end
            StBranch: begin
                alu_src_a = SRCA_REGA;
                alu_src_b = SRCB_REGB;
                alu_class = ClsSub;
                pc_source = 1'b1;
                case (iFunct3)
                    F3_BEQ:  pc_write = iZero;
                    F3_BNE:  pc_write = ~iZero;
                    default: illegal  = 1'b1;
                endcase
            end
            StJal: begin
                reg_write  = 1'b1;
                mem_to_reg = MTR_PC;
                pc_write   = 1'b1;
                pc_source  = 1'b1;
            end
            default: state_d = StFetch;
        endcase
    end

    // Reset forces every output to its idle value without waiting for a clock,
    // so no enable can pulse while reset is asserted.
    assign oPCWrite    = pc_write  & ~iRST;
    assign oIRWrite    = ir_write  & ~iRST;
    assign oMemRead    = mem_read  & ~iRST;
    assign oMemWrite   = mem_write & ~iRST;
    assign oRegWrite   = reg_write & ~iRST;
    assign oIllegal    = illegal   & ~iRST;
    assign oIorD       = iord      & ~iRST;
    assign oPCSource   = pc_source & ~iRST;
    assign oMemToReg   = iRST ? MTR_ALUOUT : mem_to_reg;
    assign oALUSrcA    = iRST ? SRCA_PC : alu_src_a;
    assign oALUSrcB    = iRST ? SRCB_REGB : alu_src_b;
    assign oALUControl = iRST ? ALUW'(ALU_ADD) : ALUW'(alu_op);
    assign oState      = STW'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle expected outputs are
// queued as each cycle's stimulus is driven and compared on the falling edge.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    logic       iCLK, iRST, iFunct7b5, iZero, iMemReady;
    logic [6:0] iOpcode;
    logic [2:0] iFunct3;
    logic       oPCWrite, oIRWrite, oMemRead, oMemWrite, oIorD, oRegWrite, oPCSource, oIllegal;
    logic [1:0] oMemToReg, oALUSrcA, oALUSrcB;
    logic [4:0] oALUControl;
    logic [3:0] oState;

    multicycle_control #(.ALUW(5), .STW(4)) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iOpcode     (iOpcode),
        .iFunct3     (iFunct3),
        .iFunct7b5   (iFunct7b5),
        .iZero       (iZero),
        .iMemReady   (iMemReady),
        .oPCWrite    (oPCWrite),
        .oIRWrite    (oIRWrite),
        .oMemRead    (oMemRead),
        .oMemWrite   (oMemWrite),
        .oIorD       (oIorD),
        .oRegWrite   (oRegWrite),
        .oMemToReg   (oMemToReg),
        .oALUSrcA    (oALUSrcA),
        .oALUSrcB    (oALUSrcB),
        .oPCSource   (oPCSource),
        .oALUControl (oALUControl),
        .oIllegal    (oIllegal),
        .oState      (oState)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, irw, mrd, mwr, iord, rw;
        logic [1:0] mtr, sa, sb;
        logic       pcs;
        logic [4:0] alu;
        logic       ill;
        logic       chk_alu;  // ALU code and A/B selects are defined in this state
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Expected outputs for one cycle, written from the state output table.
    function automatic exp_t mk(input state_e st, input logic rdy, input logic [4:0] alu,
                                input logic pcw_br, input logic ill);
        exp_t e;
        e = '0;
        e.st  = st;
        e.alu = ALU_ADD;
        e.ill = ill;
        case (st)
            StFetch: begin
                e.mrd = 1'b1; e.sa = 2'b00; e.sb = 2'b01; e.pcw = rdy; e.irw = rdy;
                e.pcs = 1'b0; e.chk_alu = 1'b1;
            end
            StDecode:   begin e.sa = 2'b10; e.sb = 2'b10; e.chk_alu = 1'b1; end
            StExecR:    begin e.sa = 2'b01; e.sb = 2'b00; e.alu = alu; e.chk_alu = !ill; end
            StExecI:    begin e.sa = 2'b01; e.sb = 2'b10; e.alu = alu; e.chk_alu = !ill; end
            StAluWb:    begin e.rw = 1'b1; e.mtr = 2'b00; end
            StMemAddr:  begin e.sa = 2'b01; e.sb = 2'b10; e.chk_alu = 1'b1; end
            StMemRead:  begin e.mrd = 1'b1; e.iord = 1'b1; end
            StMemWb:    begin e.rw = 1'b1; e.mtr = 2'b01; end
            StMemWrite: begin e.mwr = 1'b1; e.iord = 1'b1; end
            StBranch: begin
                e.sa = 2'b01; e.sb = 2'b00; e.alu = ALU_SUB; e.pcs = 1'b1; e.pcw = pcw_br;
                e.chk_alu = 1'b1;
            end
            StJal:      begin e.rw = 1'b1; e.mtr = 2'b10; e.pcw = 1'b1; e.pcs = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    // Drive one cycle of stimulus and queue what the DUT must show in it.
    task automatic step(input state_e st, input logic rdy, input logic zr, input logic [4:0] alu,
                        input logic pcw_br, input logic ill);
        iMemReady = rdy;
        iZero     = zr;
        sb_q.push_back(mk(st, rdy, alu, pcw_br, ill));
        @(posedge iCLK);
        #1;
    endtask

    task automatic st1(input state_e st);
        step(st, 1'b1, 1'b0, ALU_ADD, 1'b0, 1'b0);
    endtask

    task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        iOpcode   = op;
        iFunct3   = f3;
        iFunct7b5 = f7;
    endtask

    always @(negedge iCLK) begin
        if (!iRST) check_eq("mem_rd_wr_excl", 32'(oMemRead & oMemWrite), 32'd0);
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check_eq("state",    32'(oState),    32'(mon_e.st));
            check_eq("pcwrite",  32'(oPCWrite),  32'(mon_e.pcw));
            check_eq("irwrite",  32'(oIRWrite),  32'(mon_e.irw));
            check_eq("memread",  32'(oMemRead),  32'(mon_e.mrd));
            check_eq("memwrite", 32'(oMemWrite), 32'(mon_e.mwr));
            check_eq("regwrite", 32'(oRegWrite), 32'(mon_e.rw));
            check_eq("illegal",  32'(oIllegal),  32'(mon_e.ill));
            if (mon_e.mrd || mon_e.mwr) check_eq("iord", 32'(oIorD), 32'(mon_e.iord));
            if (mon_e.rw)  check_eq("memtoreg", 32'(oMemToReg), 32'(mon_e.mtr));
            if (mon_e.pcw) check_eq("pcsource", 32'(oPCSource), 32'(mon_e.pcs));
            if (mon_e.chk_alu) begin
                check_eq("aluctl", 32'(oALUControl), 32'(mon_e.alu));
                check_eq("srca",   32'(oALUSrcA),    32'(mon_e.sa));
                check_eq("srcb",   32'(oALUSrcB),    32'(mon_e.sb));
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        iRST = 1'b0; iMemReady = 1'b1; iZero = 1'b0;
        set_ir(7'b0, 3'b0, 1'b0);
        #1 iRST = 1'b1;
        #1;
        // Reset values, with iMemReady high to show FETCH gating is overridden.
        check_eq("rst_state",    32'(oState),      32'(StFetch));
        check_eq("rst_memread",  32'(oMemRead),    32'd0);
        check_eq("rst_irwrite",  32'(oIRWrite),    32'd0);
        check_eq("rst_pcwrite",  32'(oPCWrite),    32'd0);
        check_eq("rst_srcb",     32'(oALUSrcB),    32'd0);
        check_eq("rst_aluctl",   32'(oALUControl), 32'(ALU_ADD));
        @(posedge iCLK);
        #1 iRST = 1'b0;

        // add, sub, slt (R-type)
        set_ir(OP_RTYPE, 3'b000, 1'b0);
        st1(StFetch); st1(StDecode); step(StExecR, 1, 0, ALU_ADD, 0, 0); st1(StAluWb);
        set_ir(OP_RTYPE, 3'b000, 1'b1);
        st1(StFetch); st1(StDecode); step(StExecR, 1, 0, ALU_SUB, 0, 0); st1(StAluWb);
        set_ir(OP_RTYPE, 3'b010, 1'b0);
        st1(StFetch); st1(StDecode); step(StExecR, 1, 0, ALU_SLT, 0, 0); st1(StAluWb);
        set_ir(OP_RTYPE, 3'b110, 1'b0);
        st1(StFetch); st1(StDecode); step(StExecR, 1, 0, ALU_OR, 0, 0); st1(StAluWb);

        // andi with IR[30] set: funct7b5 must not matter for I-type
        set_ir(OP_ITYPE, 3'b111, 1'b1);
        st1(StFetch); st1(StDecode); step(StExecI, 1, 0, ALU_AND, 0, 0); st1(StAluWb);

        // lw: 3 wait cycles in FETCH, 2 in MEM_READ -> 10 cycles total
        set_ir(OP_LOAD, 3'b010, 1'b0);
        for (int i = 0; i < 3; i++) step(StFetch, 0, 0, ALU_ADD, 0, 0);
        st1(StFetch); st1(StDecode); st1(StMemAddr);
        for (int i = 0; i < 2; i++) step(StMemRead, 0, 0, ALU_ADD, 0, 0);
        st1(StMemRead); st1(StMemWb);

        // beq taken / not taken, bne not-equal taken
        set_ir(OP_BRANCH, 3'b000, 1'b0);
        st1(StFetch); st1(StDecode); step(StBranch, 1, 1, ALU_SUB, 1, 0);
        st1(StFetch); st1(StDecode); step(StBranch, 1, 0, ALU_SUB, 0, 0);
        set_ir(OP_BRANCH, 3'b001, 1'b0);
        st1(StFetch); st1(StDecode); step(StBranch, 1, 0, ALU_SUB, 1, 0);
        // unsupported branch funct3: no PC write, illegal pulse
        set_ir(OP_BRANCH, 3'b100, 1'b0);
        st1(StFetch); st1(StDecode); step(StBranch, 1, 1, ALU_SUB, 0, 1);

        // jal
        set_ir(OP_JAL, 3'b000, 1'b0);
        st1(StFetch); st1(StDecode); st1(StJal);

        // illegal opcode: pulse only in DECODE, then back to FETCH
        set_ir(7'b1111111, 3'b000, 1'b0);
        st1(StFetch); step(StDecode, 1, 0, ALU_ADD, 0, 1);
        // illegal R-type funct3: pulse in EXEC_R, no writeback
        set_ir(OP_RTYPE, 3'b001, 1'b0);
        st1(StFetch); st1(StDecode); step(StExecR, 1, 0, ALU_ADD, 0, 1);

        // sw, then reset while MEM_WRITE is waiting
        set_ir(OP_STORE, 3'b010, 1'b0);
        st1(StFetch); st1(StDecode); st1(StMemAddr);
        step(StMemWrite, 0, 0, ALU_ADD, 0, 0);
        step(StMemWrite, 0, 0, ALU_ADD, 0, 0);
        #2 iRST = 1'b1;
        #1;
        check_eq("midrst_memwrite", 32'(oMemWrite), 32'd0);
        check_eq("midrst_iord",     32'(oIorD),     32'd0);
        check_eq("midrst_state",    32'(oState),    32'(StFetch));
        @(posedge iCLK);
        #1 iRST = 1'b0;

        // clean restart: fetch with one wait, then an add
        set_ir(OP_RTYPE, 3'b000, 1'b0);
        step(StFetch, 0, 0, ALU_ADD, 0, 0);
        st1(StFetch); st1(StDecode); step(StExecR, 1, 0, ALU_ADD, 0, 0); st1(StAluWb);
        step(StFetch, 0, 0, ALU_ADD, 0, 0);

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle RV32I-subset control unit: the initiator side of the ALU control interface.
- Sequences fetch/decode/execute/memory/writeback, drives the 5-bit ALU operation code and the datapath mux selects, and handshakes with a variable-latency memory.
- Sits between instruction register / memory and the datapath registers.

Parameters:
- ALUW, 5, width of oALUControl; must match the shared ALU_* code width.
- STW, 4, state register width.

Ports:
- iCLK  in  1  clock, rising edge
- iRST  in  1  reset, asynchronous, active-high
- iOpcode  in  7  IR[6:0]
- iFunct3  in  3  IR[14:12]
- iFunct7b5  in  1  IR[30]
- iZero  in  1  ALU result == 0
- iMemReady  in  1  memory transfer completes this cycle
- oPCWrite  out  1  final PC enable, branch condition already applied
- oIRWrite  out  1  load IR and oldPC
- oMemRead  out  1  memory read request
- oMemWrite  out  1  memory write request
- oIorD  out  1  memory address select: 0=PC, 1=ALUOut
- oRegWrite  out  1  register file write
- oMemToReg  out  2  writeback select: 00=ALUOut, 01=MDR, 10=PC
- oALUSrcA  out  2  ALU A select: 00=PC, 01=regA, 10=oldPC
- oALUSrcB  out  2  ALU B select: 00=regB, 01=const 4, 10=imm
- oPCSource  out  1  PC source: 0=ALU result, 1=ALUOut
- oALUControl  out  ALUW  ALU operation, shared ALU_* code
- oIllegal  out  1  one-cycle pulse on an unsupported instruction
- oState  out  STW  current state, debug only

Behaviour:
- Reset (async, iRST high): state=FETCH. Enables (PCWrite, IRWrite, MemRead, MemWrite, RegWrite, Illegal) = 0; every select = 0; oALUControl=ALU_ADD.
- Moore outputs decoded from the state register, except:
  - oPCWrite and oIRWrite in FETCH, which are gated by iMemReady;
  - oPCWrite in BRANCH, which is gated by iZero.
- FETCH:
  - MemRead=1, IorD=0, SrcA=PC, SrcB=4, ALU_ADD, PCSource=0.
  - Stay while !iMemReady.
  - On iMemReady: IRWrite=1, PCWrite=1, next state DECODE.
- DECODE:
  - SrcA=oldPC, SrcB=imm, ALU_ADD; target latched into ALUOut.
  - Dispatch on opcode: 0110011→EXEC_R; 0010011→EXEC_I; 0000011 or 0100011→MEM_ADDR; 1100011→BRANCH; 1101111→JAL.
  - Any other opcode: oIllegal=1, next state FETCH.
- EXEC_R:
  - SrcA=regA, SrcB=regB. ALU code from funct3/funct7b5: 000/0 ADD, 000/1 SUB, 111 AND, 110 OR, 010 SLT.
  - Other funct combination: oIllegal pulse, next FETCH, no writeback.
- EXEC_I:
  - SrcB=imm. funct3 000 ADD, 111 AND, 110 OR, 010 SLT; funct7b5 ignored.
  - Other funct3: illegal, handled as in EXEC_R.
- ALU_WB: RegWrite=1, MemToReg=00, next FETCH.
- MEM_ADDR: SrcA=regA, SrcB=imm, ALU_ADD. Next MEM_READ for opcode 0000011, MEM_WRITE for 0100011.
- MEM_READ: MemRead=1, IorD=1. Wait for iMemReady, then MEM_WB.
- MEM_WB: RegWrite=1, MemToReg=01, next FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Wait for iMemReady, then FETCH.
- BRANCH:
  - SrcA=regA, SrcB=regB, ALU_SUB, PCSource=1.
  - funct3 000: PCWrite=iZero. funct3 001: PCWrite=!iZero.
  - Other funct3: PCWrite=0 and oIllegal pulse.
  - Next FETCH.
- JAL: RegWrite=1, MemToReg=10, PCWrite=1, PCSource=1, next FETCH.
- Latency with zero-wait memory:
  - R/I-type 4 cycles; load 5; store 4; branch 3; jal 3.
  - Each memory wait cycle adds one cycle.
- Memory requests (MemRead/MemWrite) are held stable while waiting. Never assert MemRead and MemWrite in the same cycle.
- Reset mid-operation (including mid-wait) aborts to FETCH immediately. No write enable may glitch high on reset.
- Unused state encodings recover to FETCH on the next clock.

Decomposition:
- Shared params file holds:
  - ALU_* codes (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT);
  - opcode constants;
  - state encodings;
  - SrcA/SrcB/MemToReg select encodings.
- One combinational sub-module, alu_op_decoder:
  - inputs: class (R, I, ADD-forced, SUB-forced), funct3, funct7b5;
  - outputs: ALU code and a legal flag.

Test Plan:
- add x3,x1,x2 (opcode 0110011, f3 000, f7b5 0), iMemReady tied 1:
  - states FETCH→DECODE→EXEC_R→ALU_WB;
  - ALU_ADD in EXEC_R; RegWrite=1 only in cycle 4.
- sub, then slt variants: oALUControl = ALU_SUB, then ALU_SLT in EXEC_R.
- lw with iMemReady low 3 cycles in FETCH and 2 in MEM_READ:
  - total 10 cycles;
  - IRWrite/PCWrite exactly one cycle each;
  - MemToReg=01 at writeback.
- beq with iZero=1: PCWrite=1, PCSource=1 in BRANCH. Same with iZero=0: PCWrite stays 0 and PC is unchanged.
- Opcode 1111111: oIllegal high for exactly the DECODE cycle, back to FETCH, no RegWrite/MemWrite.
- Assert iRST during the MEM_WRITE wait:
  - MemWrite drops asynchronously; oState=FETCH;
  - after release, a fetch restarts cleanly.
